// File: rtl/lenet_layer_sched.sv
// Layer scheduler for the LeNet accelerator: starts C1..FC2 in order, with a drain gap, a watchdog and abort.
// Optional build macro LAYER_PERF_CNT_EN adds a per-frame cycle counter that drives frame_cycles.
module lenet_layer_sched #(
   parameter int NUM_LAYERS  = 6,
   parameter int GAP_CYC     = 2,
   parameter int TIMEOUT_CYC = 65535,
   parameter int CNT_W       = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  frame_start,
   input  logic                  abort,
   input  logic                  err_clr,
   input  logic [NUM_LAYERS-1:0] layer_done,
   output logic [NUM_LAYERS-1:0] layer_start,
   output logic [2:0]            cur_layer,
   output logic                  busy,
   output logic                  frame_done,
   output logic                  err,
   output logic [2:0]            err_layer,
   output logic [31:0]           frame_cycles
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_ISSUE = 3'd1,
      S_WAIT  = 3'd2,
      S_GAP   = 3'd3,
      S_DONE  = 3'd4,
      S_ERR   = 3'd5
   } state_t;

   localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYC - 1);
   localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'((GAP_CYC > 0) ? (GAP_CYC - 1) : 0);
   localparam logic [2:0]       LAST_IDX = 3'(NUM_LAYERS - 1);
   localparam logic [NUM_LAYERS-1:0] ONE_HOT0 = NUM_LAYERS'(1);

   state_t                state_q, state_d;
   logic [2:0]            cur_q, cur_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [NUM_LAYERS-1:0] start_q, start_d;
   logic                  busy_q, busy_d;
   logic                  fdone_q, fdone_d;
   logic                  err_q, err_d;
   logic [2:0]            err_layer_q, err_layer_d;
   logic                  done_cur_s;

   assign done_cur_s = layer_done[cur_q];

   // Next-state, layer index, shared gap/watchdog counter and sticky error.
   always_comb begin
      state_d     = state_q;
      cur_d       = cur_q;
      cnt_d       = cnt_q;
      err_d       = err_q;
      err_layer_d = err_layer_q;
      if (abort) begin
         state_d     = S_IDLE;
         cur_d       = 3'd0;
         cnt_d       = '0;
         err_d       = 1'b0;
         err_layer_d = 3'd0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (frame_start) begin
                  state_d = S_ISSUE;
                  cur_d   = 3'd0;
               end else begin
                  state_d = S_IDLE;
               end
            end
            S_ISSUE: begin
               cnt_d   = '0;
               state_d = S_WAIT;
            end
            S_WAIT: begin
               // a done arriving on the last watchdog cycle still counts
               if (done_cur_s) begin
                  cnt_d = '0;
                  if (cur_q == LAST_IDX) begin
                     state_d = S_DONE;
                  end else if (GAP_CYC > 0) begin
                     state_d = S_GAP;
                  end else begin
                     state_d = S_ISSUE;
                     cur_d   = cur_q + 3'd1;
                  end
               end else if (cnt_q == TO_LAST) begin
                  state_d     = S_ERR;
                  err_d       = 1'b1;
                  err_layer_d = cur_q;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            S_GAP: begin
               if (cnt_q == GAP_LAST) begin
                  state_d = S_ISSUE;
                  cur_d   = cur_q + 3'd1;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            S_DONE: begin
               state_d = S_IDLE;
               cur_d   = 3'd0;
            end
            S_ERR: begin
               if (err_clr) begin
                  state_d = S_IDLE;
                  err_d   = 1'b0;
                  cur_d   = 3'd0;
               end else begin
                  state_d = S_ERR;
               end
            end
            default: begin
               state_d = S_IDLE;
               cur_d   = 3'd0;
               cnt_d   = '0;
            end
         endcase
      end
   end

   // Registered pulse/status outputs trail the state by one cycle; abort squashes them at once.
   always_comb begin
      start_d = '0;
      busy_d  = 1'b0;
      fdone_d = 1'b0;
      if (abort) begin
         start_d = '0;
         busy_d  = 1'b0;
         fdone_d = 1'b0;
      end else begin
         busy_d  = (state_q != S_IDLE) && (state_q != S_ERR);
         fdone_d = (state_q == S_DONE);
         if (state_q == S_ISSUE) begin
            start_d = ONE_HOT0 << cur_q;
         end else begin
            start_d = '0;
         end
      end
   end

   // Control and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         cur_q       <= 3'd0;
         cnt_q       <= '0;
         start_q     <= '0;
         busy_q      <= 1'b0;
         fdone_q     <= 1'b0;
         err_q       <= 1'b0;
         err_layer_q <= 3'd0;
      end else begin
         state_q     <= state_d;
         cur_q       <= cur_d;
         cnt_q       <= cnt_d;
         start_q     <= start_d;
         busy_q      <= busy_d;
         fdone_q     <= fdone_d;
         err_q       <= err_d;
         err_layer_q <= err_layer_d;
      end
   end

   assign layer_start = start_q;
   assign cur_layer   = cur_q;
   assign busy        = busy_q;
   assign frame_done  = fdone_q;
   assign err         = err_q;
   assign err_layer   = err_layer_q;

`ifdef LAYER_PERF_CNT_EN
   logic [31:0] perf_q, perf_d;
   logic [31:0] fcyc_q, fcyc_d;

   // Saturating frame cycle counter, snapshotted on the DONE cycle.
   always_comb begin
      perf_d = perf_q;
      fcyc_d = fcyc_q;
      if ((state_q == S_IDLE) && frame_start && !abort) begin
         perf_d = 32'd0;
      end else if ((state_q != S_IDLE) && (state_q != S_ERR) && (perf_q != 32'hFFFF_FFFF)) begin
         perf_d = perf_q + 32'd1;
      end else begin
         perf_d = perf_q;
      end
      if ((state_q == S_DONE) && !abort) begin
         fcyc_d = perf_q;
      end else begin
         fcyc_d = fcyc_q;
      end
   end

   // Performance counter registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_q <= 32'd0;
         fcyc_q <= 32'd0;
      end else begin
         perf_q <= perf_d;
         fcyc_q <= fcyc_d;
      end
   end

   assign frame_cycles = fcyc_q;
`else
   assign frame_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_lenet_layer_sched.sv
// Self-checking bench for lenet_layer_sched: a GAP_CYC=2 instance and a GAP_CYC=0 instance, TIMEOUT_CYC=20.
module tb_lenet_layer_sched;
   localparam int T = 20;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        fs1, fs2, abort, err_clr;
   logic [5:0]  done1, done2, ls1, ls2;
   logic [2:0]  cur1, cur2, el1, el2;
   logic        busy1, busy2, fd1, fd2, err1, err2;
   logic [31:0] fc1, fc2;

   int     checks = 0;
   int     errors = 0;
   longint cyc = 0;

   typedef struct {
      int     kind;   // 0: layer_start, 1: frame_done
      int     idx;
      longint edge_n;
   } exp_t;
   exp_t exp_q[$];

   lenet_layer_sched #(.NUM_LAYERS(6), .GAP_CYC(2), .TIMEOUT_CYC(T), .CNT_W(16)) dut (
      .clk(clk), .rst_n(rst_n), .frame_start(fs1), .abort(abort), .err_clr(err_clr),
      .layer_done(done1), .layer_start(ls1), .cur_layer(cur1), .busy(busy1),
      .frame_done(fd1), .err(err1), .err_layer(el1), .frame_cycles(fc1));

   lenet_layer_sched #(.NUM_LAYERS(6), .GAP_CYC(0), .TIMEOUT_CYC(T), .CNT_W(16)) dut_g0 (
      .clk(clk), .rst_n(rst_n), .frame_start(fs2), .abort(abort), .err_clr(err_clr),
      .layer_done(done2), .layer_start(ls2), .cur_layer(cur2), .busy(busy2),
      .frame_done(fd2), .err(err2), .err_layer(el2), .frame_cycles(fc2));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Runs one frame on the chosen instance, returning early when layer 'hang' is started.
   task automatic run_frame(input bit inst, input int d, input int d2, input int hang,
                            input bit stray, input bit hold, input longint k_pre,
                            output bit fin, output longint s_hang, output longint k_next);
      exp_t        ex;
      int          gap, cur;
      longint      done_at, k, m, s;
      logic [5:0]  ls, dv, oh;
      logic        fd, fsv;
      logic [31:0] fc, fc_exp;
      gap = inst ? 0 : 2;
      fin = 1'b0; s_hang = -1; k_next = -1;
      cur = 0; done_at = -1; m = 0; s = 0;
      if (k_pre < 0) begin
         k = cyc + 1;
         exp_q.push_back(exp_t'{0, 0, k + 1});
         if (inst) fs2 = 1'b1; else fs1 = 1'b1;
         tick;
         if (!hold) begin fs1 = 1'b0; fs2 = 1'b0; end
      end else begin
         k = k_pre;
      end
      for (int n = 0; n < 500; n++) begin
         ls = inst ? ls2 : ls1;
         fd = inst ? fd2 : fd1;
         if (ls != 6'd0 || fd) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_output: cycle %0d layer_start=%b frame_done=%b, required none", cyc, ls, fd);
            end else begin
               ex = exp_q.pop_front();
               oh = 6'b000001 << ex.idx;
               if (ex.kind == 1) oh = 6'd0;
               if (ls !== oh || fd !== (ex.kind == 1) || cyc != ex.edge_n) begin
                  errors++;
                  $display("FAIL sequence: cycle %0d layer_start=%b frame_done=%b, required cycle %0d layer_start=%b frame_done=%0d",
                           cyc, ls, fd, ex.edge_n, oh, ex.kind);
               end
               if (ex.kind == 0) begin
                  cur = ex.idx; s = cyc;
                  if (cur == hang) s_hang = cyc;
                  else done_at = cyc + ((cur == 2) ? d2 : d);
               end else begin
                  fin = 1'b1;
               end
            end
         end
         if (fin || s_hang >= 0) break;
         dv = 6'd0;
         if (done_at == cyc + 1) begin
            dv = 6'b000001 << cur;
            if (cur < 5) exp_q.push_back(exp_t'{0, cur + 1, cyc + 1 + gap + 1});
            else begin exp_q.push_back(exp_t'{1, 0, cyc + 2}); m = cyc + 1; end
         end
         if (stray && cur == 2 && cyc == s + 3) dv[4] = 1'b1;
         fsv = hold || (stray && cur == 2 && cyc == s + 5);
         if (inst) begin done2 = dv; fs2 = fsv; end else begin done1 = dv; fs1 = fsv; end
         tick;
      end
      done1 = 6'd0; done2 = 6'd0;
      if (fin) begin
         fc = inst ? fc2 : fc1;
`ifdef LAYER_PERF_CNT_EN
         fc_exp = 32'(m - k);
`else
         fc_exp = 32'd0;
`endif
         checks++;
         if (fc !== fc_exp) begin
            errors++; $display("FAIL frame_cycles: got %0d, required %0d", fc, fc_exp);
         end
         checks++;
         if ((inst ? err2 : err1) !== 1'b0 || exp_q.size() != 0) begin
            errors++; $display("FAIL frame_end_state: err=%b pending=%0d, required err=0 pending=0",
                               inst ? err2 : err1, exp_q.size());
            exp_q.delete();
         end
         if (hold) begin exp_q.push_back(exp_t'{0, 0, cyc + 2}); k_next = cyc + 1; end
         tick;
         fs1 = 1'b0; fs2 = 1'b0;
         checks++;
         if ((inst ? busy2 : busy1) !== 1'b0 || (inst ? cur2 : cur1) !== 3'd0) begin
            errors++; $display("FAIL post_frame_idle: busy=%b cur_layer=%0d, required busy=0 cur_layer=0",
                               inst ? busy2 : busy1, inst ? cur2 : cur1);
         end
      end
   endtask

   task automatic check_fin(input string name, input bit fin);
      checks++;
      if (!fin) begin errors++; $display("FAIL %s: frame did not complete, required frame_done", name); end
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({ls1, cur1, busy1, fd1, err1, el1, fc1, ls2, cur2, busy2, fd2, err2, el2, fc2} !== '0) begin
         errors++; $display("FAIL reset_values: got ls=%b cur=%0d busy=%b fd=%b err=%b el=%0d fc=%0d, required all 0",
                            ls1, cur1, busy1, fd1, err1, el1, fc1);
      end
      @(negedge clk) rst_n = 1'b1;
      repeat (2) tick;
      checks++;
      if (busy1 !== 1'b0 || ls1 !== 6'd0) begin
         errors++; $display("FAIL idle_after_reset: busy=%b ls=%b, required 0", busy1, ls1);
      end
   endtask

   task automatic test_nominal;
      bit fin; longint sh, kn;
      run_frame(1'b0, 10, 10, -1, 1'b0, 1'b0, -1, fin, sh, kn);
      check_fin("nominal", fin);
   endtask

   task automatic test_stray;
      bit fin; longint sh, kn;
      run_frame(1'b0, 10, T, -1, 1'b1, 1'b0, -1, fin, sh, kn);
      check_fin("stray_and_done_on_timeout", fin);
   endtask

   task automatic test_timeout;
      bit fin, fd_seen; longint sh, kn;
      run_frame(1'b0, 10, 10, 3, 1'b0, 1'b0, -1, fin, sh, kn);
      checks++;
      if (sh < 0) begin
         errors++; $display("FAIL timeout_layer3_start: never seen, required layer_start[3]");
         return;
      end
      fd_seen = 1'b0;
      repeat (T - 1) begin tick; fd_seen |= fd1; end
      checks++;
      if (err1 !== 1'b0) begin errors++; $display("FAIL timeout_early: err=%b at start+%0d, required 0", err1, T - 1); end
      tick; fd_seen |= fd1;
      checks++;
      if (err1 !== 1'b1 || el1 !== 3'd3) begin
         errors++; $display("FAIL timeout_err: err=%b err_layer=%0d, required err=1 err_layer=3", err1, el1);
      end
      tick; fd_seen |= fd1;
      checks++;
      if (busy1 !== 1'b0 || fd_seen) begin
         errors++; $display("FAIL timeout_busy: busy=%b frame_done_seen=%b, required 0 and 0", busy1, fd_seen);
      end
      fs1 = 1'b1; tick; fs1 = 1'b0; tick; tick;
      checks++;
      if (ls1 !== 6'd0 || busy1 !== 1'b0 || err1 !== 1'b1) begin
         errors++; $display("FAIL err_ignores_start: ls=%b busy=%b err=%b, required 0 0 1", ls1, busy1, err1);
      end
      err_clr = 1'b1; tick; err_clr = 1'b0;
      checks++;
      if (err1 !== 1'b0) begin errors++; $display("FAIL err_clr: err=%b, required 0", err1); end
      run_frame(1'b0, 10, 10, -1, 1'b0, 1'b0, -1, fin, sh, kn);
      check_fin("after_err_clr", fin);
   endtask

   task automatic test_abort;
      bit fin, bad; longint sh, kn;
      run_frame(1'b0, 10, 10, 1, 1'b0, 1'b0, -1, fin, sh, kn);
      repeat (3) tick;
      abort = 1'b1; fs1 = 1'b1; done1 = 6'b000010;
      tick;
      abort = 1'b0; fs1 = 1'b0; done1 = 6'd0;
      checks++;
      if (busy1 !== 1'b0 || ls1 !== 6'd0 || fd1 !== 1'b0 || cur1 !== 3'd0 || err1 !== 1'b0 || sh < 0) begin
         errors++; $display("FAIL abort_state: busy=%b ls=%b fd=%b cur=%0d err=%b, required all 0", busy1, ls1, fd1, cur1, err1);
      end
      bad = 1'b0;
      repeat (4) begin tick; if (busy1 !== 1'b0 || ls1 !== 6'd0 || fd1 !== 1'b0) bad = 1'b1; end
      checks++;
      if (bad) begin errors++; $display("FAIL abort_no_restart: activity seen=%b, required 0", bad); end
      run_frame(1'b0, 10, 10, -1, 1'b0, 1'b0, -1, fin, sh, kn);
      check_fin("after_abort", fin);
   endtask

   task automatic test_gap0;
      bit fin; longint sh, kn;
      run_frame(1'b1, 1, 1, -1, 1'b0, 1'b0, -1, fin, sh, kn);
      check_fin("gap0", fin);
   endtask

   task automatic test_back_to_back;
      bit fin; longint sh, kn;
      run_frame(1'b1, 1, 1, -1, 1'b0, 1'b1, -1, fin, sh, kn);
      check_fin("back_to_back_first", fin);
      if (kn >= 0) begin
         run_frame(1'b1, 1, 1, -1, 1'b0, 1'b0, kn, fin, sh, kn);
         check_fin("back_to_back_second", fin);
      end
   endtask

   task automatic test_async_reset;
      bit fin; longint sh, kn;
      run_frame(1'b0, 10, 10, 0, 1'b0, 1'b0, -1, fin, sh, kn);
      done1 = 6'b000001; tick; done1 = 6'd0; tick;
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({ls1, cur1, busy1, fd1, err1, el1, fc1} !== '0) begin
         errors++; $display("FAIL async_reset: ls=%b cur=%0d busy=%b fd=%b err=%b el=%0d fc=%0d, required all 0",
                            ls1, cur1, busy1, fd1, err1, el1, fc1);
      end
      @(negedge clk) rst_n = 1'b1;
      tick;
      run_frame(1'b0, 10, 10, -1, 1'b0, 1'b0, -1, fin, sh, kn);
      check_fin("after_async_reset", fin);
   endtask

   initial begin
      fs1 = 1'b0; fs2 = 1'b0; abort = 1'b0; err_clr = 1'b0;
      done1 = 6'd0; done2 = 6'd0;
      test_reset;
      test_nominal;
      test_stray;
      test_timeout;
      test_abort;
      test_gap0;
      test_back_to_back;
      test_async_reset;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end
endmodule
